// File: rtl/colour_pkg.sv
// Shared definitions for the fp32 colour-channel to 8-bit integer conversion paths.
package colour_pkg;

  localparam int          FP32_BIAS       = 127;
  localparam int          FP32_EXP_MAX    = 255;
  localparam int          COLOUR_SCALE    = 255;
  localparam logic [31:0] COLOUR_ONE_FP32 = 32'h3F800000;

  typedef enum logic [2:0] {
    CLS_NORMAL,
    CLS_ZERO,
    CLS_NEG,
    CLS_NAN,
    CLS_SAT
  } colour_cls_t;

endpackage

// File: rtl/colour_fp32_classify.sv
// Combinational fp32 decode: input class, 24-bit significand and the right-shift
// that scales significand*255 down to an integer colour value.
module colour_fp32_classify
  import colour_pkg::*;
(
  input  logic [31:0] data_i,
  output colour_cls_t cls_o,
  output logic [23:0] mant_o,
  output logic [7:0]  shift_o,
  output logic        is_one_o
);

  logic        w_sign;
  logic [7:0]  w_exp;
  logic [22:0] w_frac;

  assign w_sign = data_i[31];
  assign w_exp  = data_i[30:23];
  assign w_frac = data_i[22:0];

  // Priority order matters: NaN before sign, and a negative zero stays a plain zero.
  always_comb begin
    cls_o = CLS_NORMAL;
    if (w_exp == 8'(FP32_EXP_MAX) && w_frac != '0) begin
      cls_o = CLS_NAN;
    end else if (w_sign && (w_exp != '0 || w_frac != '0)) begin
      cls_o = CLS_NEG;
    end else if (w_exp == '0) begin
      cls_o = CLS_ZERO;
    end else if (w_exp >= 8'(FP32_BIAS)) begin
      cls_o = CLS_SAT;
    end
  end

  assign mant_o   = {1'b1, w_frac};
  assign shift_o  = 8'd150 - w_exp;
  assign is_one_o = (data_i == COLOUR_ONE_FP32);

endmodule

// File: rtl/colour_float_to_int.sv
// Three-stage fp32 [0,1] colour channel to 8-bit integer converter, round(x*255)
// with ties upward, out-of-range inputs clamped and flagged.
module colour_float_to_int
  import colour_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [31:0] data_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [7:0]  data_o,
  output logic        clamp_o
);

  logic        w_advance;
  colour_cls_t w_cls;
  logic [23:0] w_mant;
  logic [7:0]  w_shift;
  logic        w_isOne;

  logic        r_s1Valid;
  colour_cls_t r_s1Cls;
  logic [23:0] r_s1Mant;
  logic [7:0]  r_s1Shift;
  logic        r_s1IsOne;

  logic        r_s2Valid;
  colour_cls_t r_s2Cls;
  logic [31:0] r_s2Prod;
  logic [7:0]  r_s2Shift;
  logic        r_s2IsOne;

  logic [32:0] w_sum;
  logic [7:0]  w_shifted;
  logic [7:0]  w_normVal;
  logic [7:0]  w_resData;
  logic        w_resClamp;

  // The whole pipe moves together; bubbles are kept, not squeezed out.
  assign w_advance = ~valid_o | ready_i;
  assign ready_o   = w_advance;

  colour_fp32_classify u_classify (
    .data_i   (data_i),
    .cls_o    (w_cls),
    .mant_o   (w_mant),
    .shift_o  (w_shift),
    .is_one_o (w_isOne)
  );

  // Sum needs 33 bits: at shift 32 the rounding constant is 2^31 on top of P.
  assign w_sum     = {1'b0, r_s2Prod} + (33'd1 << (r_s2Shift - 8'd1));
  assign w_shifted = 8'(w_sum >> r_s2Shift);
  assign w_normVal = (r_s2Shift >= 8'd33) ? 8'h00 : w_shifted;

  always_comb begin
    w_resData  = 8'h00;
    w_resClamp = 1'b0;
    case (r_s2Cls)
      CLS_NORMAL: w_resData = w_normVal;
      CLS_SAT: begin
        w_resData  = 8'hFF;
        w_resClamp = ~r_s2IsOne;
      end
      CLS_NEG, CLS_NAN: w_resClamp = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_s1Valid <= 1'b0;
      r_s1Cls   <= CLS_ZERO;
      r_s1Mant  <= '0;
      r_s1Shift <= '0;
      r_s1IsOne <= 1'b0;
      r_s2Valid <= 1'b0;
      r_s2Cls   <= CLS_ZERO;
      r_s2Prod  <= '0;
      r_s2Shift <= '0;
      r_s2IsOne <= 1'b0;
      valid_o   <= 1'b0;
      data_o    <= 8'h00;
      clamp_o   <= 1'b0;
    end else if (w_advance) begin
      r_s1Valid <= valid_i;
      r_s1Cls   <= w_cls;
      r_s1Mant  <= w_mant;
      r_s1Shift <= w_shift;
      r_s1IsOne <= w_isOne;
      r_s2Valid <= r_s1Valid;
      r_s2Cls   <= r_s1Cls;
      r_s2Prod  <= {r_s1Mant, 8'h00} - {8'h00, r_s1Mant};
      r_s2Shift <= r_s1Shift;
      r_s2IsOne <= r_s1IsOne;
      valid_o   <= r_s2Valid;
      data_o    <= w_resData;
      clamp_o   <= w_resClamp;
    end
  end

endmodule

// File: tb/tb_colour_float_to_int.sv
// Directed bench for colour_float_to_int: vector tables streamed through the pipe,
// plus hand-written latency, backpressure and mid-stream reset sequences.
module tb_colour_float_to_int;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] data_i;
  logic        valid_o;
  logic        ready_i;
  logic [7:0]  data_o;
  logic        clamp_o;

  typedef struct {
    logic [31:0] din;
    logic [7:0]  expData;
    logic        expClamp;
  } vec_t;

  vec_t vecs[300];
  vec_t dirTable[16];
  int   testCount = 0;
  int   failCount = 0;
  int   lat;

  colour_float_to_int dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (data_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o),
    .clamp_o (clamp_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Integer model of the 8-bit-to-float mapping: fp32 nearest to n/255.
  function automatic logic [31:0] fwdMap(input int n);
    logic [63:0] a;
    logic [63:0] mant;
    int          kk;
    int          ex;
    if (n == 0) return 32'h0;
    kk = 0;
    while (((64'(n)) << kk) < (64'd255 << 23)) kk++;
    a    = 64'(n) << kk;
    mant = (a + 64'd127) / 64'd255;
    if (mant >= 64'd16777216) begin
      mant = mant >> 1;
      kk   = kk - 1;
    end
    ex = 150 - kk;
    return {1'b0, 8'(ex), mant[22:0]};
  endfunction

  // Streams vecs[0..n-1], scoreboarding outputs in order; returns first-output latency.
  task automatic applyStimulus(input int n, input bit randReady, input string tag, output int latency);
    int         sent = 0;
    int         got = 0;
    int         cycles = 0;
    int         cAcc = -1;
    int         cOut = -1;
    logic [8:0] expQ[$];
    logic [8:0] heldPrev = '0;
    logic [8:0] e;
    bit         stallPrev = 1'b0;
    while (got < n && cycles < 2000) begin
      @(negedge clk_i);
      cycles++;
      if (stallPrev)
        checkOutput($sformatf("%s hold", tag), {22'b0, valid_o, clamp_o, data_o}, {22'b0, 1'b1, heldPrev});
      ready_i = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      checkOutput($sformatf("%s ready_o", tag), {31'b0, ready_o}, {31'b0, ~valid_o | ready_i});
      if (valid_o && cOut < 0) cOut = cycles;
      if (valid_o && ready_i) begin
        if (expQ.size() == 0) begin
          checkOutput($sformatf("%s unexpected word", tag), {23'b0, clamp_o, data_o}, 32'hDEAD);
        end else begin
          e = expQ.pop_front();
          checkOutput($sformatf("%s word %0d", tag, got), {23'b0, clamp_o, data_o}, {23'b0, e});
        end
        got++;
      end
      stallPrev = valid_o && !ready_i;
      heldPrev  = {clamp_o, data_o};
      if (sent < n) begin
        valid_i = 1'b1;
        data_i  = vecs[sent].din;
        if (ready_o) begin
          expQ.push_back({vecs[sent].expClamp, vecs[sent].expData});
          if (cAcc < 0) cAcc = cycles;
          sent++;
        end
      end else begin
        valid_i = 1'b0;
        data_i  = $urandom;
      end
    end
    if (got < n)
      checkOutput($sformatf("%s timeout words", tag), got, n);
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(negedge clk_i);
    checkOutput($sformatf("%s drained", tag), {31'b0, valid_o}, 32'h0);
    latency = cOut - cAcc;
  endtask

  initial begin
    rst_i   = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    data_i  = '0;

    dirTable[0]  = '{32'h3F000000, 8'd128, 1'b0};
    dirTable[1]  = '{32'h3AFFFFFF, 8'd0,   1'b0};
    dirTable[2]  = '{32'h3B008081, 8'd1,   1'b0};
    dirTable[3]  = '{32'h00000001, 8'd0,   1'b0};
    dirTable[4]  = '{32'h3F800000, 8'd255, 1'b0};
    dirTable[5]  = '{32'h40000000, 8'd255, 1'b1};
    dirTable[6]  = '{32'h7F800000, 8'd255, 1'b1};
    dirTable[7]  = '{32'hBF000000, 8'd0,   1'b1};
    dirTable[8]  = '{32'h7FC00000, 8'd0,   1'b1};
    dirTable[9]  = '{32'h80000000, 8'd0,   1'b0};
    dirTable[10] = '{32'h3E800000, 8'd64,  1'b0};
    dirTable[11] = '{32'h80000001, 8'd0,   1'b1};
    dirTable[12] = '{32'hFF800000, 8'd0,   1'b1};
    dirTable[13] = '{32'h7F800001, 8'd0,   1'b1};
    dirTable[14] = '{32'h3F7FFFFF, 8'd255, 1'b0};
    dirTable[15] = '{32'h3F7EFEFF, 8'd254, 1'b0};

    #2;
    checkOutput("reset valid_o", {31'b0, valid_o}, 32'h0);
    checkOutput("reset data_o",  {24'b0, data_o},  32'h0);
    checkOutput("reset clamp_o", {31'b0, clamp_o}, 32'h0);
    checkOutput("reset ready_o", {31'b0, ready_o}, 32'h1);
    @(negedge clk_i);
    rst_i = 1'b0;

    for (int n = 0; n < 256; n++) vecs[n] = '{fwdMap(n), 8'(n), 1'b0};
    checkOutput("fwd map n=1",   vecs[1].din,   32'h3B808081);
    checkOutput("fwd map n=128", vecs[128].din, 32'h3F008081);
    applyStimulus(256, 1'b0, "sweep", lat);
    checkOutput("sweep first latency", lat, 3);

    for (int i = 0; i < 16; i++) vecs[i] = dirTable[i];
    applyStimulus(16, 1'b0, "directed", lat);

    for (int i = 0; i < 10; i++) vecs[i] = dirTable[(i * 7 + 3) % 16];
    applyStimulus(10, 1'b1, "backpressure", lat);
    for (int i = 0; i < 10; i++) vecs[i] = '{fwdMap(i * 25 + 3), 8'(i * 25 + 3), 1'b0};
    applyStimulus(10, 1'b1, "backpressure2", lat);

    // Three words in flight, then an asynchronous reset between clock edges.
    @(negedge clk_i);
    ready_i = 1'b1;
    valid_i = 1'b1;
    data_i  = 32'h3F000000;
    @(negedge clk_i);
    data_i  = 32'h3E800000;
    @(negedge clk_i);
    data_i  = 32'h3F800000;
    @(negedge clk_i);
    valid_i = 1'b0;
    checkOutput("preReset valid_o", {31'b0, valid_o}, 32'h1);
    checkOutput("preReset data_o",  {24'b0, data_o},  32'd128);
    @(posedge clk_i);
    #3;
    rst_i = 1'b1;
    #1;
    checkOutput("midReset valid_o", {31'b0, valid_o}, 32'h0);
    checkOutput("midReset data_o",  {24'b0, data_o},  32'h0);
    checkOutput("midReset clamp_o", {31'b0, clamp_o}, 32'h0);
    checkOutput("midReset ready_o", {31'b0, ready_o}, 32'h1);
    @(negedge clk_i);
    rst_i   = 1'b0;
    valid_i = 1'b1;
    data_i  = 32'h3E800000;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk_i);
      valid_i = 1'b0;
      checkOutput($sformatf("postReset valid_o obs%0d", i), {31'b0, valid_o}, {31'b0, i == 3});
      if (i == 3) checkOutput("postReset data_o", {23'b0, clamp_o, data_o}, 32'd64);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
